// File: rtl/alu_pkg.sv
// Shared EX-stage ALU definitions: function codes, ALU select encodings,
// the issue-buffer state type and the default-width buffer entry layout.
package alu_pkg;

  // Decoded ALU function codes from ID (8..15 are illegal).
  localparam logic [3:0] FUNC_ADD = 4'd0;
  localparam logic [3:0] FUNC_SUB = 4'd1;
  localparam logic [3:0] FUNC_SEQ = 4'd2;
  localparam logic [3:0] FUNC_SNE = 4'd3;
  localparam logic [3:0] FUNC_SLT = 4'd4;
  localparam logic [3:0] FUNC_SGT = 4'd5;
  localparam logic [3:0] FUNC_SLE = 4'd6;
  localparam logic [3:0] FUNC_SGE = 4'd7;

  // ALU select vectors {sel4,sel3,sel2,sel1,sel0}; don't-cares driven 0.
  localparam logic [4:0] CTRL_ADD     = 5'b00000;
  localparam logic [4:0] CTRL_SUB     = 5'b11000;
  localparam logic [4:0] CTRL_SEQ     = 5'b10000;
  localparam logic [4:0] CTRL_SNE     = 5'b10001;
  localparam logic [4:0] CTRL_SLT     = 5'b10010;
  localparam logic [4:0] CTRL_SGT     = 5'b10011;
  localparam logic [4:0] CTRL_SLE     = 5'b10100;
  localparam logic [4:0] CTRL_SGE     = 5'b10110;
  localparam logic [4:0] CTRL_ILLEGAL = 5'b00000;

  localparam int ALU_DATA_W = 32;

  // Occupancy of the 2-entry skid buffer.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

  // One buffered beat at the default operand width.
  typedef struct packed {
    logic [ALU_DATA_W-1:0] in1;
    logic [ALU_DATA_W-1:0] in2;
    logic [4:0]            ctrl;
    logic                  illegal;
  } alu_entry_t;

endpackage

// File: rtl/alu_issue_if.sv
// ID -> issue -> EX bundle for the ALU issue stage.
// Handshake: a beat transfers on a rising clk edge where valid & ready are
// both 1; the sender holds valid and payload stable until that edge, and
// ready never depends combinationally on valid of the same channel.
interface alu_issue_if #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_func;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [IMM_W-1:0]  in_imm;
  logic              in_use_imm;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_in1;
  logic [DATA_W-1:0] out_in2;
  logic [4:0]        out_ctrl;
  logic              out_illegal;
  logic [CNT_W-1:0]  illegal_cnt;

  // Environment side: drives ID beats and EX back-pressure.
  modport master (
    output in_valid, in_func, in_a, in_b, in_imm, in_use_imm, flush, out_ready,
    input  in_ready, out_valid, out_in1, out_in2, out_ctrl, out_illegal, illegal_cnt
  );

  // Issue stage side.
  modport slave (
    input  in_valid, in_func, in_a, in_b, in_imm, in_use_imm, flush, out_ready,
    output in_ready, out_valid, out_in1, out_in2, out_ctrl, out_illegal, illegal_cnt
  );
endinterface

// File: rtl/alu_func_enc.sv
// Maps a 4-bit ALU function code to the ALU select vector and an illegal flag.
module alu_func_enc
  import alu_pkg::*;
(
  input  logic [3:0] func,
  output logic [4:0] ctrl,
  output logic       illegal
);

  // Pure table lookup; codes 8..15 produce a zero select and raise illegal.
  always_comb begin
    ctrl    = CTRL_ILLEGAL;
    illegal = 1'b0;
    case (func)
      FUNC_ADD: ctrl = CTRL_ADD;
      FUNC_SUB: ctrl = CTRL_SUB;
      FUNC_SEQ: ctrl = CTRL_SEQ;
      FUNC_SNE: ctrl = CTRL_SNE;
      FUNC_SLT: ctrl = CTRL_SLT;
      FUNC_SGT: ctrl = CTRL_SGT;
      FUNC_SLE: ctrl = CTRL_SLE;
      FUNC_SGE: ctrl = CTRL_SGE;
      default: begin
        ctrl    = CTRL_ILLEGAL;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: encodes the function, selects operand 2 and presents the
// beat to EX through a 2-entry skid buffer so in_ready is purely registered.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_issue_if.slave bus,
  output buf_state_t dbg_state
);

  // Same layout as alu_entry_t, sized by this instance's DATA_W.
  typedef struct packed {
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [4:0]        ctrl;
    logic              illegal;
  } entry_t;

  buf_state_t       state_q, state_d;
  entry_t           main_q, skid_q, new_entry;
  logic             main_ld, main_from_skid, skid_ld;
  logic             accept, deliver;
  logic [4:0]       enc_ctrl;
  logic             enc_illegal;
  logic [CNT_W-1:0] cnt_q;

  alu_func_enc u_enc (
    .func    (bus.in_func),
    .ctrl    (enc_ctrl),
    .illegal (enc_illegal)
  );

  // Build the final entry before buffering: operand 2 mux and encoding.
  always_comb begin
    new_entry.in1     = bus.in_a;
    new_entry.in2     = bus.in_use_imm
                        ? {{(DATA_W-IMM_W){bus.in_imm[IMM_W-1]}}, bus.in_imm}
                        : bus.in_b;
    new_entry.ctrl    = enc_ctrl;
    new_entry.illegal = enc_illegal;
  end

  assign bus.in_ready    = (state_q != BUF_TWO);
  assign bus.out_valid   = (state_q != BUF_EMPTY);
  assign accept          = bus.in_valid & bus.in_ready;
  assign deliver         = bus.out_valid & bus.out_ready;
  assign bus.out_in1     = main_q.in1;
  assign bus.out_in2     = main_q.in2;
  assign bus.out_ctrl    = main_q.ctrl;
  assign bus.out_illegal = main_q.illegal;
  assign bus.illegal_cnt = cnt_q;
  assign dbg_state       = state_q;

  // Next-state and entry load decisions; flush overrides everything.
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    if (bus.flush) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (accept) begin
            state_d = BUF_ONE;
            main_ld = 1'b1;
          end
        end
        BUF_ONE: begin
          if (accept && !deliver) begin
            state_d = BUF_TWO;
            skid_ld = 1'b1;
          end else if (accept && deliver) begin
            state_d = BUF_ONE;
            main_ld = 1'b1;
          end else if (deliver) begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          if (deliver) begin
            state_d        = BUF_ONE;
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
  end

  // Buffer occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BUF_EMPTY;
    else        state_q <= state_d;
  end

  // Main and skid payload registers; payload is left as-is when emptied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_ld) main_q <= main_from_skid ? skid_q : new_entry;
      if (skid_ld) skid_q <= new_entry;
    end
  end

  // Saturating count of accepted, non-flushed illegal beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept && enc_illegal && !bus.flush && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: encoding table, immediate extension, skid
// back-pressure ordering, flush, illegal counting/saturation and async reset.
module tb_alu_issue;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;
  buf_state_t dbg_state;
  int         n_checks;
  int         n_pass;
  logic [31:0] exp_q[$];

  alu_issue_if #(.DATA_W(32), .IMM_W(16), .CNT_W(16)) bus ();

  alu_issue #(.DATA_W(32), .IMM_W(16), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one cycle; sample and drive 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] imm, input logic use_imm);
    bus.in_valid   = v;
    bus.in_func    = f;
    bus.in_a       = a;
    bus.in_b       = b;
    bus.in_imm     = imm;
    bus.in_use_imm = use_imm;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(bus.in_ready),    64'd1);
    check({tag, "_out_valid"}, 64'(bus.out_valid),   64'd0);
    check({tag, "_in1"},       64'(bus.out_in1),     64'd0);
    check({tag, "_in2"},       64'(bus.out_in2),     64'd0);
    check({tag, "_ctrl"},      64'(bus.out_ctrl),    64'd0);
    check({tag, "_illegal"},   64'(bus.out_illegal), 64'd0);
    check({tag, "_cnt"},       64'(bus.illegal_cnt), 64'd0);
  endtask

  logic [4:0] ctrl_tbl [8];
  int         seen;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    ctrl_tbl[0] = 5'b00000; ctrl_tbl[1] = 5'b11000;
    ctrl_tbl[2] = 5'b10000; ctrl_tbl[3] = 5'b10001;
    ctrl_tbl[4] = 5'b10010; ctrl_tbl[5] = 5'b10011;
    ctrl_tbl[6] = 5'b10100; ctrl_tbl[7] = 5'b10110;

    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 16'd0, 1'b0);
    step();
    step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // SLT, register operand: visible one cycle after accept.
    drive(1'b1, 4'd4, 32'd5, 32'd9, 16'h1234, 1'b0);
    step();
    check("slt_valid", 64'(bus.out_valid), 64'd1);
    check("slt_ctrl",  64'(bus.out_ctrl),  64'b10010);
    check("slt_in1",   64'(bus.out_in1),   64'd5);
    check("slt_in2",   64'(bus.out_in2),   64'd9);
    bus.in_valid = 1'b0;
    step();
    check("slt_drained", 64'(bus.out_valid), 64'd0);

    // SGE with negative immediate; ALU would compute 0 >= -2.
    drive(1'b1, 4'd7, 32'd0, 32'h5555_5555, 16'hFFFE, 1'b1);
    step();
    check("sge_in2",  64'(bus.out_in2),  64'hFFFF_FFFE);
    check("sge_ctrl", 64'(bus.out_ctrl), 64'b10110);
    check("sge_alu",  64'($signed(bus.out_in1) >= $signed(bus.out_in2)), 64'd1);
    // Positive immediate extends with zeros.
    drive(1'b1, 4'd0, 32'd1, 32'hFFFF_FFFF, 16'h7001, 1'b1);
    step();
    check("imm_pos_in2", 64'(bus.out_in2), 64'h0000_7001);
    bus.in_valid = 1'b0;
    step();

    // Encoding table at full throughput.
    for (int f = 0; f < 8; f++) begin
      drive(1'b1, 4'(f), 32'(f + 100), 32'(f + 200), 16'd0, 1'b0);
      step();
      check($sformatf("enc_ctrl_%0d", f), 64'(bus.out_ctrl), 64'(ctrl_tbl[f]));
      check($sformatf("enc_in1_%0d", f),  64'(bus.out_in1),  64'(f + 100));
    end
    bus.in_valid = 1'b0;
    step();

    // Illegal code 11.
    drive(1'b1, 4'd11, 32'd3, 32'd4, 16'd0, 1'b0);
    step();
    check("ill_flag", 64'(bus.out_illegal), 64'd1);
    check("ill_ctrl", 64'(bus.out_ctrl),    64'd0);
    check("ill_cnt",  64'(bus.illegal_cnt), 64'd1);
    bus.in_valid = 1'b0;
    step();

    // Flush in ONE with an incoming illegal beat: dropped and not counted.
    bus.out_ready = 1'b0;
    drive(1'b1, 4'd0, 32'd7, 32'd7, 16'd0, 1'b0);
    step();
    drive(1'b1, 4'd12, 32'd8, 32'd8, 16'd0, 1'b0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush1_valid", 64'(bus.out_valid),   64'd0);
    check("flush1_cnt",   64'(bus.illegal_cnt), 64'd1);

    // Flush in TWO coincident with in_valid: nothing ever emerges.
    drive(1'b1, 4'd0, 32'd21, 32'd0, 16'd0, 1'b0);
    step();
    drive(1'b1, 4'd1, 32'd22, 32'd0, 16'd0, 1'b0);
    step();
    check("two_in_ready", 64'(bus.in_ready), 64'd0);
    check("two_state",    64'(dbg_state),    64'(BUF_TWO));
    drive(1'b1, 4'd2, 32'd23, 32'd0, 16'd0, 1'b0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush2_valid", 64'(bus.out_valid), 64'd0);
    check("flush2_ready", 64'(bus.in_ready),  64'd1);
    bus.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.out_valid) seen++;
      step();
    end
    check("flush2_no_beat", 64'(seen), 64'd0);

    // Three-beat stream with EX stalled, then released: strict FIFO order.
    bus.out_ready = 1'b0;
    exp_q.push_back(32'd31);
    exp_q.push_back(32'd32);
    exp_q.push_back(32'd33);
    drive(1'b1, 4'd0, 32'd31, 32'd0, 16'd0, 1'b0);
    step();
    check("s_one_ready", 64'(bus.in_ready), 64'd1);
    drive(1'b1, 4'd0, 32'd32, 32'd0, 16'd0, 1'b0);
    step();
    check("s_two_ready", 64'(bus.in_ready), 64'd0);
    drive(1'b1, 4'd0, 32'd33, 32'd0, 16'd0, 1'b0);
    step();
    check("s_stall_ready", 64'(bus.in_ready), 64'd0);
    check("s_stall_hold",  64'(bus.out_in1),  64'd31);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("s_order_valid_%0d", i), 64'(bus.out_valid), 64'd1);
      if (exp_q.size() > 0) check($sformatf("s_order_%0d", i), 64'(bus.out_in1), 64'(exp_q.pop_front()));
      step();
      if (i == 1) bus.in_valid = 1'b0;
    end
    check("s_drained", 64'(bus.out_valid), 64'd0);
    check("s_queue_empty", 64'(exp_q.size()), 64'd0);

    // Saturation: counter at 1, 65534 more illegal beats reach all-ones.
    drive(1'b1, 4'd9, 32'd0, 32'd0, 16'd0, 1'b0);
    for (int i = 0; i < 65534; i++) step();
    check("cnt_full", 64'(bus.illegal_cnt), 64'hFFFF);
    for (int i = 0; i < 4; i++) step();
    check("cnt_sat", 64'(bus.illegal_cnt), 64'hFFFF);

    // Async reset mid-stream with a valid beat on the outputs.
    drive(1'b1, 4'd1, 32'hDEAD_BEEF, 32'h1234_5678, 16'd0, 1'b0);
    step();
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_valid", 64'(bus.out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Operand/control issue stage that drives the EX-stage arithmetic ALU. Accepts a decoded ALU function code plus operands from ID over a valid/ready handshake. Selects register or sign-extended immediate for the second operand and encodes the function into the ALU's 5-bit select vector. Presents a registered, back-pressurable beat to EX through a 2-entry skid buffer, so ID never sees a combinational ready path from EX.

## Interface
- `DATA_W`, default 32: operand width.
- `IMM_W`, default 16: immediate width, sign-extended to `DATA_W`.
- `CNT_W`, default 16: width of the illegal-op counter.
- `clk` in 1: single clock. All logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: ID beat present.
- `in_ready` out 1: stage can accept a beat.
- `in_func` in 4: function code. 0 ADD, 1 SUB, 2 SEQ, 3 SNE, 4 SLT, 5 SGT, 6 SLE, 7 SGE, 8–15 illegal.
- `in_a` in `DATA_W`: operand 1.
- `in_b` in `DATA_W`: register operand 2.
- `in_imm` in `IMM_W`: immediate.
- `in_use_imm` in 1: 1 selects sign-extended `in_imm` as operand 2.
- `flush` in 1: synchronous kill of all buffered beats.
- `out_valid` out 1: EX beat present.
- `out_ready` in 1: EX accepts the beat.
- `out_in1` out `DATA_W`: ALU operand 1.
- `out_in2` out `DATA_W`: ALU operand 2.
- `out_ctrl` out 5: ALU select vector, `{sel4,sel3,sel2,sel1,sel0}`.
- `out_illegal` out 1: beat carries an illegal function code.
- `illegal_cnt` out `CNT_W`: count of accepted illegal beats.

## Operation
- Encoding of `out_ctrl`; every don't-care is driven 0:
  - ADD 00000
  - SUB 11000
  - SEQ 10000
  - SNE 10001
  - SLT 10010
  - SGT 10011
  - SLE 10100
  - SGE 10110
  - illegal 00000 with `out_illegal`=1
- Operand 2 is `in_use_imm ? {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm} : in_b`.
- Encoding and immediate selection happen before the buffer. Buffer entries hold the final `{in1, in2, ctrl, illegal}`.
- Buffer states:
  - EMPTY: no valid entry.
  - ONE: main entry valid.
  - TWO: main and skid entries valid.
- Handshakes: accept when `in_valid & in_ready`. Deliver when `out_valid & out_ready`.
- Transitions:
  - EMPTY, accept → ONE.
  - ONE, accept and no deliver → TWO; the new beat goes to skid.
  - ONE, accept and deliver → ONE; main reloads with the new beat.
  - ONE, deliver only → EMPTY.
  - TWO, deliver → ONE; skid moves to main. No accept is possible in TWO.
- `in_ready` = state != TWO. It is a registered state decode, with no combinational path from `out_ready`.
- `out_valid` = state != EMPTY. Output fields come from the main entry.
- `flush` has priority over every other event. Next state is EMPTY and any concurrent input beat is dropped. A flushed illegal beat is not counted.
- `illegal_cnt` increments on each accepted beat with `in_func`≥8, unless `flush` is high that cycle. It saturates at all-ones.
- Ordering is strict FIFO. No beat is duplicated or lost except by `flush`.

## Timing
- Latency: an accepted beat is on the outputs the next cycle (`out_valid`=1).
- Throughput: 1 beat/cycle while `out_ready`=1.
- After `out_ready` deasserts, one further beat is absorbed into skid. `in_ready` drops the following cycle.
- Reset: state EMPTY, `in_ready`=1, `out_valid`=0, `out_in1`/`out_in2`=0, `out_ctrl`=00000, `out_illegal`=0, `illegal_cnt`=0.
- Reset asserted mid-transfer discards all entries asynchronously.
- Output payload holds stable while `out_valid`=1 and `out_ready`=0.

## Structure
- Shared package `alu_pkg` holds:
  - the function-code constants (`FUNC_ADD`…`FUNC_SGE`);
  - the 5-bit control constants (`CTRL_ADD`…`CTRL_SGE`);
  - a packed struct type for a buffer entry `{in1, in2, ctrl, illegal}`.
- One combinational sub-module, `alu_func_enc`, maps the 4-bit function code to `{ctrl, illegal}`. It is reusable by other EX-stage units.
- The skid buffer and the counter stay in `alu_issue`.

## Test plan
- Reset, then `in_func`=4, `in_a`=5, `in_b`=9, `out_ready`=1 → next cycle `out_valid`=1, `out_ctrl`=10010, `out_in2`=9.
- `in_use_imm`=1, `in_imm`=16'hFFFE, SGE, sent to the ALU → `out_in2`=32'hFFFFFFFE, `out_ctrl`=10110. With `in_a`=0 the ALU returns 1.
- Stream of 3 beats with `out_ready`=0 from cycle 1:
  - beats 1–2 are buffered and `in_ready`=0;
  - beat 3 stalls;
  - raise `out_ready` → beats 1, 2, 3 emerge in order on consecutive cycles.
- `flush` in state TWO coincident with `in_valid` → next cycle `out_valid`=0, `in_ready`=1, no beat ever emerges.
- `in_func`=11 → `out_illegal`=1, `out_ctrl`=00000, `illegal_cnt` 0→1. Preload the counter near all-ones via a long stream and check it saturates.
- Assert `rst_n`=0 asynchronously mid-stream with `out_valid`=1 → all outputs at reset values before the next clock edge.
